uart_cmd_parser: RTL and testbench

- Sits directly downstream of the high-speed UART receiver (2 Mbps at 50 MHz).
- Consumes that receiver's byte stream: `uart_done` is a multi-cycle high level and `uart_data` is valid while it is high.
- Frames fixed-format command packets (SYNC, CMD, LEN, payload, CHK), verifies the checksum and buffers the payload.
- Presents each good command to the host logic through a valid/ack handshake, with a random-access payload read port.

---
 rtl/uart_cmd_parser_pkg.sv | 33 +++
 rtl/uart_cmd_parser_if.sv | 38 +++
 rtl/uart_byte_strobe.sv | 42 ++++
 rtl/uart_cmd_parser.sv | 186 ++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser_pkg
// Description : Shared state encoding, framing constants and checksum helper
//               for the UART command parser.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_parser_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_CHK  = 3'd4,
        S_PEND = 3'd5
    } state_t;

    localparam logic [7:0] c_SYNC_BYTE   = 8'hA5;
    localparam int         c_MAX_LEN     = 16;
    // 1 ms of inter-byte silence at 50 MHz
    localparam int         c_TIMEOUT_CYC = 50000;

    function automatic logic [7:0] chk_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

    function automatic logic is_timed(input state_t s);
        return (s == S_CMD) || (s == S_LEN) || (s == S_DATA) || (s == S_CHK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_parser_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser_if
// Description : Receiver byte stream, host command handshake, payload read
//               port and error pulses of the UART command parser.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_parser_if #(
    parameter int MAX_LEN = 16
) ();
    localparam int c_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic            uart_done;
    logic [7:0]      uart_data;
    logic            cmd_valid;
    logic            cmd_ack;
    logic [7:0]      cmd_code;
    logic [7:0]      cmd_len;
    logic [c_AW-1:0] rd_addr;
    logic [7:0]      rd_data;
    logic            err_chk;
    logic            err_len;
    logic            err_timeout;
    logic            err_ovr;

    modport master (
        output uart_done, uart_data, cmd_ack, rd_addr,
        input  cmd_valid, cmd_code, cmd_len, rd_data,
               err_chk, err_len, err_timeout, err_ovr
    );

    modport slave (
        input  uart_done, uart_data, cmd_ack, rd_addr,
        output cmd_valid, cmd_code, cmd_len, rd_data,
               err_chk, err_len, err_timeout, err_ovr
    );
endinterface
`default_nettype wire

// File: rtl/uart_byte_strobe.sv
`default_nettype none
// ============================================================================
// Module      : uart_byte_strobe
// Description : Turns the receiver's multi-cycle done level into a 1-cycle
//               byte strobe with the byte captured on the rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_strobe (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_uart_done,
    input  wire logic [7:0] i_uart_data,
    output logic            o_byte_stb,
    output logic [7:0]      o_byte_data
);

    logic       r_done_d;
    logic       r_stb;
    logic [7:0] r_data;
    logic       w_rise;

    assign w_rise = i_uart_done & ~r_done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done_d <= 1'b0;
            r_stb    <= 1'b0;
            r_data   <= 8'h00;
        end else begin
            r_done_d <= i_uart_done;
            r_stb    <= w_rise;
            if (w_rise) begin
                r_data <= i_uart_data;
            end
        end
    end

    assign o_byte_stb  = r_stb;
    assign o_byte_data = r_data;

endmodule
`default_nettype wire

// File: rtl/uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_parser
// Description : Frames SYNC/CMD/LEN/payload/CHK packets from the UART byte
//               stream, verifies the checksum and hands good commands to the
//               host over a valid/ack handshake with a payload read port.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_parser
    import uart_cmd_parser_pkg::*;
#(
    parameter int         MAX_LEN     = c_MAX_LEN,
    parameter logic [7:0] SYNC_BYTE   = c_SYNC_BYTE,
    parameter int         TIMEOUT_CYC = c_TIMEOUT_CYC
) (
    input  wire logic         sys_clk,
    input  wire logic         sys_rst,
    uart_cmd_parser_if.slave  bus
);

    localparam int c_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int c_TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CYC - 1);

    logic            w_stb;
    logic [7:0]      w_byte;

    state_t          r_state, w_state_nxt;
    logic [7:0]      r_code,  w_code_nxt;
    logic [7:0]      r_len,   w_len_nxt;
    logic [7:0]      r_sum,   w_sum_nxt;
    logic [c_AW-1:0] r_idx,   w_idx_nxt;
    logic [c_TW-1:0] r_tcnt,  w_tcnt_nxt;
    logic            r_err_chk, r_err_len, r_err_timeout, r_err_ovr;
    logic            w_err_chk, w_err_len, w_err_timeout, w_err_ovr;
    logic            w_buf_we;
    logic [7:0]      r_rd_data;
    logic [7:0]      r_buf [MAX_LEN];

    uart_byte_strobe u_strobe (
        .clk         (sys_clk),
        .rst         (sys_rst),
        .i_uart_done (bus.uart_done),
        .i_uart_data (bus.uart_data),
        .o_byte_stb  (w_stb),
        .o_byte_data (w_byte)
    );

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state       <= S_IDLE;
            r_code        <= 8'h00;
            r_len         <= 8'h00;
            r_sum         <= 8'h00;
            r_idx         <= '0;
            r_tcnt        <= '0;
            r_err_chk     <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_err_ovr     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_code        <= w_code_nxt;
            r_len         <= w_len_nxt;
            r_sum         <= w_sum_nxt;
            r_idx         <= w_idx_nxt;
            r_tcnt        <= w_tcnt_nxt;
            r_err_chk     <= w_err_chk;
            r_err_len     <= w_err_len;
            r_err_timeout <= w_err_timeout;
            r_err_ovr     <= w_err_ovr;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_code_nxt    = r_code;
        w_len_nxt     = r_len;
        w_sum_nxt     = r_sum;
        w_idx_nxt     = r_idx;
        w_tcnt_nxt    = '0;
        w_err_chk     = 1'b0;
        w_err_len     = 1'b0;
        w_err_timeout = 1'b0;
        w_err_ovr     = 1'b0;
        w_buf_we      = 1'b0;

        // A strobe arriving in the expiry cycle takes priority over the timeout
        if (is_timed(r_state) && !w_stb) begin
            if (r_tcnt == c_TO_LAST) begin
                w_err_timeout = 1'b1;
                w_state_nxt   = S_IDLE;
            end else begin
                w_tcnt_nxt = r_tcnt + 1'b1;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (w_stb && (w_byte == SYNC_BYTE)) begin
                    w_state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                if (w_stb) begin
                    w_code_nxt  = w_byte;
                    w_sum_nxt   = w_byte;
                    w_state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (w_stb) begin
                    w_len_nxt = w_byte;
                    w_sum_nxt = chk_add(r_sum, w_byte);
                    if (int'(w_byte) > MAX_LEN) begin
                        w_err_len   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (w_byte == 8'h00) begin
                        w_state_nxt = S_CHK;
                    end else begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_stb) begin
                    w_buf_we  = 1'b1;
                    w_sum_nxt = chk_add(r_sum, w_byte);
                    if (8'(r_idx) == (r_len - 8'd1)) begin
                        w_state_nxt = S_CHK;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                    end
                end
            end
            S_CHK: begin
                if (w_stb) begin
                    if (w_byte == r_sum) begin
                        w_state_nxt = S_PEND;
                    end else begin
                        w_err_chk   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_PEND: begin
                // Everything is frozen; bytes arriving now are lost
                w_err_ovr = w_stb;
                if (bus.cmd_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (w_buf_we) begin
            r_buf[r_idx] <= w_byte;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_rd_data <= 8'h00;
        end else if (int'(bus.rd_addr) < MAX_LEN) begin
            r_rd_data <= r_buf[bus.rd_addr];
        end else begin
            r_rd_data <= 8'h00;
        end
    end

    assign bus.cmd_valid   = (r_state == S_PEND);
    assign bus.cmd_code    = r_code;
    assign bus.cmd_len     = r_len;
    assign bus.rd_data     = r_rd_data;
    assign bus.err_chk     = r_err_chk;
    assign bus.err_len     = r_err_len;
    assign bus.err_timeout = r_err_timeout;
    assign bus.err_ovr     = r_err_ovr;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_parser
// Description : Scoreboard bench for uart_cmd_parser: directed frames plus
//               random traffic checked against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_parser;

    localparam int MAX_LEN = 16;
    localparam int TO_CYC  = 50000;
    localparam int AW      = 4;

    typedef enum int {EV_CHK = 0, EV_LEN = 1, EV_TO = 2, EV_OVR = 3} ev_t;
    typedef struct { ev_t kind; int due; } err_exp_t;
    typedef struct {
        logic [7:0]                code;
        logic [7:0]                len;
        logic [MAX_LEN-1:0][7:0]   pl;
    } good_exp_t;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    uart_cmd_parser_if #(.MAX_LEN(MAX_LEN)) bus ();

    uart_cmd_parser #(
        .MAX_LEN     (MAX_LEN),
        .SYNC_BYTE   (8'hA5),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    err_exp_t  err_q[$];
    good_exp_t good_q[$];
    int checks = 0, failures = 0;
    int acks = 0, exp_acks = 0;
    int last_byte_cyc = 0;
    bit hold_mode = 0, ovr1_done = 0, reads_done = 0, release_ack = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ack_sync);
        @(negedge sys_clk);
        bus.uart_data = b;
        bus.uart_done = 1'b1;
        last_byte_cyc = cyc;
        if (ack_sync) begin
            @(posedge sys_clk);
            #1 release_ack = 1'b1;
        end
        repeat (13) @(negedge sys_clk);
        bus.uart_done = 1'b0;
        bus.uart_data = 8'($urandom);
        repeat ($urandom_range(1, 5)) @(negedge sys_clk);
    endtask

    // chk_sel: -1 correct checksum, -2 corrupted checksum, else literal byte
    task automatic send_frame(input logic [7:0] code, input logic [7:0] len,
                              input logic [MAX_LEN-1:0][7:0] pl, input int chk_sel);
        int         sum;
        logic [7:0] chk;
        good_exp_t  g;
        sum = int'(code) + int'(len);
        if (int'(len) > MAX_LEN) begin
            err_q.push_back('{EV_LEN, 0});
            send_byte(8'hA5, 1'b0);
            send_byte(code, 1'b0);
            send_byte(len, 1'b0);
            return;
        end
        for (int i = 0; i < int'(len); i++) sum += int'(pl[i]);
        if (chk_sel == -1)      chk = 8'(sum % 256);
        else if (chk_sel == -2) chk = 8'((sum + $urandom_range(1, 255)) % 256);
        else                    chk = 8'(chk_sel);
        if (int'(chk) == sum % 256) begin
            g.code = code;
            g.len  = len;
            g.pl   = pl;
            good_q.push_back(g);
            exp_acks++;
        end else begin
            err_q.push_back('{EV_CHK, 0});
        end
        send_byte(8'hA5, 1'b0);
        send_byte(code, 1'b0);
        send_byte(len, 1'b0);
        for (int i = 0; i < int'(len); i++) send_byte(pl[i], 1'b0);
        send_byte(chk, 1'b0);
    endtask

    task automatic send_garbage(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            send_byte(b, 1'b0);
        end
    endtask

    task automatic wait_acks();
        int t = 0;
        while (acks < exp_acks && t < 3000) begin
            @(negedge sys_clk);
            t++;
        end
        if (acks < exp_acks) fail("ack_wait_expired");
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_valid"}, 32'(bus.cmd_valid), 0);
        check({tag, "_cmd_code"},  32'(bus.cmd_code), 0);
        check({tag, "_cmd_len"},   32'(bus.cmd_len), 0);
        check({tag, "_rd_data"},   32'(bus.rd_data), 0);
        check({tag, "_errs"}, 32'({bus.err_chk, bus.err_len, bus.err_timeout, bus.err_ovr}), 0);
    endtask

    // Error monitor: every pulse must match the next expected error
    initial begin
        int       n;
        ev_t      kind;
        err_exp_t e;
        forever begin
            @(negedge sys_clk);
            n = int'(bus.err_chk) + int'(bus.err_len) + int'(bus.err_timeout) + int'(bus.err_ovr);
            if (n > 1) begin
                fail("err_not_exclusive");
            end else if (n == 1) begin
                kind = bus.err_chk ? EV_CHK : bus.err_len ? EV_LEN : bus.err_timeout ? EV_TO : EV_OVR;
                if (err_q.size() == 0) begin
                    $display("FAIL unexpected_err: got kind %0d expected none", kind);
                    checks++;
                    failures++;
                end else begin
                    e = err_q.pop_front();
                    check("err_kind", 32'(kind), 32'(e.kind));
                    if (e.kind == EV_TO && kind == EV_TO) begin
                        checks++;
                        if (cyc < e.due - 3 || cyc > e.due + 3) begin
                            failures++;
                            $display("FAIL timeout_timing: got cycle %0d expected %0d", cyc, e.due);
                        end
                    end
                end
            end
        end
    end

    // Host monitor: consumes each pending command and checks its contents
    initial begin
        good_exp_t e;
        bus.cmd_ack = 1'b0;
        bus.rd_addr = '0;
        forever begin
            @(negedge sys_clk);
            if (bus.cmd_valid === 1'b1) begin
                if (good_q.size() == 0) begin
                    fail("unexpected_cmd_valid");
                    e.code = 8'h00;
                    e.len  = 8'h00;
                    e.pl   = '0;
                end else begin
                    e = good_q.pop_front();
                end
                check("cmd_code", 32'(bus.cmd_code), 32'(e.code));
                check("cmd_len",  32'(bus.cmd_len),  32'(e.len));
                if (hold_mode) begin
                    wait (ovr1_done);
                    @(negedge sys_clk);
                end
                for (int i = 0; i < int'(e.len) && i < MAX_LEN; i++) begin
                    bus.rd_addr = AW'(i);
                    @(negedge sys_clk);
                    check("rd_data", 32'(bus.rd_data), 32'(e.pl[i]));
                end
                check("cmd_code_frozen", 32'(bus.cmd_code), 32'(e.code));
                check("cmd_valid_held",  32'(bus.cmd_valid), 1);
                if (hold_mode) begin
                    reads_done = 1'b1;
                    wait (release_ack);
                end
                bus.cmd_ack = 1'b1;
                @(posedge sys_clk);
                #1 bus.cmd_ack = 1'b0;
                @(negedge sys_clk);
                check("cmd_valid_after_ack", 32'(bus.cmd_valid), 0);
                acks++;
            end
        end
    end

    initial begin
        logic [MAX_LEN-1:0][7:0] pl;
        logic [7:0] len;
        int t;
        bus.uart_done = 1'b0;
        bus.uart_data = 8'h00;

        repeat (3) @(negedge sys_clk);
        check_all_zero("reset");
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);

        // Good frame A5 10 02 33 44 89
        pl = '0; pl[0] = 8'h33; pl[1] = 8'h44;
        send_frame(8'h10, 8'h02, pl, 'h89);
        wait_acks();

        // Bad checksum, then zero-length good frame
        send_frame(8'h10, 8'h02, pl, 'h88);
        send_frame(8'h01, 8'h00, pl, 'h01);
        wait_acks();

        // LEN above MAX_LEN, trailing bytes ignored
        send_frame(8'h20, 8'h11, pl, -1);
        send_byte(8'h10, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h33, 1'b0);

        // Inter-byte timeout
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        err_q.push_back('{EV_TO, last_byte_cyc + TO_CYC + 2});
        repeat (TO_CYC + 20) @(negedge sys_clk);
        check("timeout_drained", 32'(err_q.size()), 0);
        pl[2] = 8'h7E;
        send_frame(8'h33, 8'h03, pl, -1);
        wait_acks();

        // Overrun while pending, including a byte coincident with ack
        hold_mode = 1'b1;
        pl = '0; pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_frame(8'h42, 8'h03, pl, -1);
        t = 0;
        while (bus.cmd_valid !== 1'b1 && t < 200) begin @(negedge sys_clk); t++; end
        if (bus.cmd_valid !== 1'b1) fail("pend_wait_expired");
        err_q.push_back('{EV_OVR, 0});
        send_byte(8'h55, 1'b0);
        ovr1_done = 1'b1;
        t = 0;
        while (!reads_done && t < 200) begin @(negedge sys_clk); t++; end
        if (!reads_done) fail("reads_wait_expired");
        err_q.push_back('{EV_OVR, 0});
        send_byte(8'h55, 1'b1);
        wait_acks();
        hold_mode = 1'b0; ovr1_done = 1'b0; reads_done = 1'b0; release_ack = 1'b0;

        // Reset mid-payload
        send_byte(8'hA5, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h99, 1'b0);
        #3 sys_rst = 1'b1;
        #1 check_all_zero("async_rst");
        repeat (2) @(negedge sys_clk);
        check_all_zero("held_rst");
        sys_rst = 1'b0;
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        pl = '0; pl[0] = 8'hC3;
        send_frame(8'h5C, 8'h01, pl, -1);
        wait_acks();

        // Random traffic
        for (int f = 0; f < 40; f++) begin
            int kind = $urandom_range(0, 9);
            for (int i = 0; i < MAX_LEN; i++) pl[i] = 8'($urandom);
            len = 8'($urandom_range(0, MAX_LEN));
            if (kind <= 5) begin
                send_frame(8'($urandom), len, pl, -1);
                wait_acks();
            end else if (kind <= 7) begin
                send_frame(8'($urandom), len, pl, -2);
            end else if (kind == 8) begin
                send_frame(8'($urandom), 8'($urandom_range(MAX_LEN + 1, 255)), pl, -1);
                send_garbage($urandom_range(0, 3));
            end else begin
                send_garbage($urandom_range(1, 3));
            end
        end

        t = 0;
        while ((err_q.size() != 0 || good_q.size() != 0 || acks < exp_acks) && t < 3000) begin
            @(negedge sys_clk);
            t++;
        end
        check("err_q_drained",  32'(err_q.size()), 0);
        check("good_q_drained", 32'(good_q.size()), 0);
        check("acks_total",     32'(acks), 32'(exp_acks));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
